multi_clock_divider: RTL
========================

# multi_clock_divider

Parametrised N-channel programmable clock divider generating independent divided clock levels and single-cycle tick strobes from one system clock. Each channel has a runtime-writable divisor and high-time, updated glitch-free at period boundaries through shadow registers. Feeds display-scan, debounce-sample and audio/PWM timing logic that previously each needed a dedicated fixed-ratio divider.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- DIV_W, 26, width of divisor/high-time fields (26 covers a 50 MHz base to 1 Hz)
- DEFAULT_DIV, 50000000, reset divisor of every channel; reset high-time is DEFAULT_DIV/2
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- en  input  NUM_CH  per-channel run enable
- wr_en  input  1  config write strobe
- wr_ch  input  max(1,$clog2(NUM_CH))  target channel; values >= NUM_CH ignored
- wr_div  input  DIV_W  new period in clk cycles
- wr_high  input  DIV_W  new high time in clk cycles
- out_clk  output  NUM_CH  divided clock level, registered
- tick  output  NUM_CH  one-cycle strobe at each period start, registered
- pending  output  NUM_CH  shadow config written but not yet applied

## Operation
- Per channel: active {div, high}, shadow {div, high}, pending flag, counter (DIV_W bits).
- Reset (reset==0 at an edge): active and shadow = {DEFAULT_DIV, DEFAULT_DIV/2}; counter=0; out_clk=0, tick=0, pending=0.
- Channel live when en=1 and active div >= 2. Not live: counter held 0, out_clk=0, tick=0.
- Live: counter 0..div-1, wraps to 0 after div-1. high_eff = min(high, div-1). out_clk_next = (counter < high_eff); tick_next = (counter == 0).
- high=0 gives constant-low out_clk; ticks still issued.
- Write: wr_en=1 with valid wr_ch loads shadow, sets pending. Later writes before apply overwrite (last wins).
- Apply: at the edge where a live counter equals div-1, or any edge where channel not live, active <= shadow, pending cleared, counter -> 0.
- Write in the same cycle as a wrap: wrap uses prior shadow state; new write remains pending until next wrap.
- en falling: counter cleared next edge. en rising: counting starts at 0.
- Arithmetic unsigned; counter compare against div-1 computed at DIV_W bits, no division in hardware.

## Timing
- Outputs one register stage after counter: tick and out_clk rise together one cycle after counter==0.
- Period exactly div cycles; out_clk high exactly high_eff cycles per period.
- First tick after reset release or en rise: 1 cycle after counter starts at 0.
- Config latency: applied on the first wrap after the write; worst case div+1 cycles.
- Reset asserted mid-period overrides everything on that edge, including pending writes.

## Configuration
- CLKDIV_SYNC_EN defined: adds input sync (1 bit). sync=1 at an edge forces every live channel counter to 0 and applies any pending shadow immediately; all live channels tick on the following cycle, phase-aligned. sync has priority over normal wrap; lower priority than reset.
- Undefined: no sync port; channels align only via reset or en.

## Structure
- Package clkdiv_pkg: DIV_W default constant, typedef struct packed {div, high} clkdiv_cfg_t, and reset-value constant.
- Sub-module clock_divider_channel: one channel (counter, active/shadow, pending, output regs); top instantiates NUM_CH via generate and decodes wr_ch.

## Test plan
- DEFAULT_DIV=10, reset released, en=4'b0001 -> ch0 tick every 10 cycles, out_clk high 5 / low 5; other channels low.
- Write ch1 div=4 high=1 mid-period of div=10 -> pending[1]=1 until wrap, then period 4 with 1-cycle high; pending cleared.
- Write div=1 or div=0 -> channel outputs held 0; write div=6 afterwards applies next cycle (not live).
- high=9 with div=6 -> clamped, out_clk high 5 / low 1; high=0 -> out_clk constant 0, tick every 6.
- Write arriving on wrap cycle, then second write before next wrap -> first wrap unchanged, second value applied at following wrap.
- With CLKDIV_SYNC_EN: ch0 div=8, ch1 div=12 free-running, pulse sync -> both tick on the next cycle; reset low mid-run -> all outputs 0 on that edge.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants and config record for the programmable clock divider.
package clkdiv_pkg;
  localparam int CLKDIV_DIV_W       = 26;
  localparam int CLKDIV_DEFAULT_DIV = 50000000;

  typedef struct packed {
    logic [CLKDIV_DIV_W-1:0] div;
    logic [CLKDIV_DIV_W-1:0] high;
  } clkdiv_cfg_t;

  localparam clkdiv_cfg_t CLKDIV_RST_CFG = '{
    div:  CLKDIV_DIV_W'(CLKDIV_DEFAULT_DIV),
    high: CLKDIV_DIV_W'(CLKDIV_DEFAULT_DIV / 2)
  };

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active/shadow config, registered clock/tick.
// CLKDIV_SYNC_EN adds a sync input that restarts the counter and applies shadow.
module clock_divider_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = CLKDIV_DIV_W,
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_high,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             out_clk,
  output logic             tick,
  output logic             pending
);
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] high;
  } cfg_t;

  localparam cfg_t RST_CFG = '{div: DIV_W'(DEFAULT_DIV), high: DIV_W'(DEFAULT_DIV / 2)};

  cfg_t             act, shd;
  logic [DIV_W-1:0] cnt, div_m1, high_eff;
  logic             live, wrap, restart;

  always_comb begin
    div_m1   = act.div - DIV_W'(1);
    live     = en && (act.div >= DIV_W'(2));
    high_eff = (act.high > div_m1) ? div_m1 : act.high;
    wrap     = live && (cnt == div_m1);
`ifdef CLKDIV_SYNC_EN
    restart  = !live || wrap || sync;
`else
    restart  = !live || wrap;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      act     <= RST_CFG;
      shd     <= RST_CFG;
      cnt     <= '0;
      out_clk <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (restart) begin
        act     <= shd;
        pending <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      // A write on the apply edge lands after the apply, so it waits for the next period.
      if (wr) begin
        shd     <= '{div: wr_div, high: wr_high};
        pending <= 1'b1;
      end
      out_clk <= live && (cnt < high_eff);
      tick    <= live && (cnt == '0);
    end
  end
endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider: decodes config writes and fans out channels.
// CLKDIV_SYNC_EN adds a sync input that phase-aligns all live channels.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = CLKDIV_DIV_W,
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV,
  localparam int CH_W       = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic [DIV_W-1:0]  wr_high,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] out_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);
  logic [NUM_CH-1:0] wr_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel numbers never match any index, so they are dropped.
    assign wr_sel[i] = wr_en && (int'(wr_ch) == i);

    clock_divider_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (en[i]),
      .wr     (wr_sel[i]),
      .wr_div (wr_div),
      .wr_high(wr_high),
`ifdef CLKDIV_SYNC_EN
      .sync   (sync),
`endif
      .out_clk(out_clk[i]),
      .tick   (tick[i]),
      .pending(pending[i])
    );
  end
endmodule
